// File: rtl/seq_pkg.sv
// Shared types and defaults for the loop sequencer.
package seq_pkg;

   localparam int unsigned IdxWidthDefault = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Index counter that steps on enable and wraps to zero after reaching its terminal value.
module wrap_counter
   import seq_pkg::*;
#(
   parameter int unsigned IDX_WIDTH = IdxWidthDefault
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [IDX_WIDTH-1:0] term_i,
   output logic [IDX_WIDTH-1:0] idx_o,
   output logic                 wrap_o
);

   logic [IDX_WIDTH-1:0] idx_q, idx_d;

   assign wrap_o = en_i && (idx_q == term_i);
   assign idx_o  = idx_q;

   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (en_i) begin
         idx_d = wrap_o ? '0 : idx_q + IDX_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/loop_sequencer.sv
// Row/column index generator streaming rows*cols beats with a start/done handshake.
module loop_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned IDX_WIDTH = IdxWidthDefault
) (
   input  logic                 seq_clk,
   input  logic                 seq_rst,
   input  logic                 seq_start_i,
   input  logic [IDX_WIDTH-1:0] seq_rows_i,
   input  logic [IDX_WIDTH-1:0] seq_cols_i,
   output logic                 seq_busy_o,
   output logic                 seq_done_o,
   output logic                 seq_valid_o,
   input  logic                 seq_ready_i,
   output logic [IDX_WIDTH-1:0] seq_row_o,
   output logic [IDX_WIDTH-1:0] seq_col_o,
   output logic                 seq_last_o,
   output logic                 seq_cnt_en_o
);

   seq_state_e           state_q, state_d;
   logic [IDX_WIDTH-1:0] rows_q, rows_d, cols_q, cols_d;
   logic [IDX_WIDTH-1:0] rows_m1, cols_m1;
   logic                 start_ok, bounds_nz, capture, fire, last_idx, col_wrap, row_wrap;

   assign start_ok  = (state_q == IDLE) && seq_start_i;
   assign bounds_nz = (seq_rows_i != '0) && (seq_cols_i != '0);
   assign capture   = start_ok && bounds_nz;
   assign fire      = seq_valid_o && seq_ready_i;
   assign rows_m1   = rows_q - IDX_WIDTH'(1);
   assign cols_m1   = cols_q - IDX_WIDTH'(1);
   assign last_idx  = (seq_row_o == rows_m1) && (seq_col_o == cols_m1);

   // On the final beat both counters wrap, leaving the indices at zero for the next run.
   wrap_counter #(
      .IDX_WIDTH(IDX_WIDTH)
   ) u_col (
      .clk_i (seq_clk),
      .rst_i (seq_rst),
      .clr_i (capture),
      .en_i  (fire),
      .term_i(cols_m1),
      .idx_o (seq_col_o),
      .wrap_o(col_wrap)
   );

   wrap_counter #(
      .IDX_WIDTH(IDX_WIDTH)
   ) u_row (
      .clk_i (seq_clk),
      .rst_i (seq_rst),
      .clr_i (capture),
      .en_i  (col_wrap),
      .term_i(rows_m1),
      .idx_o (seq_row_o),
      .wrap_o(row_wrap)
   );

   always_comb begin
      rows_d = rows_q;
      cols_d = cols_q;
      if (capture) begin
         rows_d = seq_rows_i;
         cols_d = seq_cols_i;
      end
   end

   always_ff @(posedge seq_clk) begin
      if (seq_rst) begin
         state_q <= IDLE;
         rows_q  <= '0;
         cols_q  <= '0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (seq_start_i) state_d = bounds_nz ? RUN : DONE;
         RUN:     if (fire && last_idx) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      seq_valid_o  = (state_q == RUN);
      seq_busy_o   = (state_q != IDLE);
      seq_done_o   = (state_q == DONE);
      seq_last_o   = seq_valid_o && last_idx;
      seq_cnt_en_o = seq_valid_o && seq_ready_i;
   end

   logic unused_wrap;
   assign unused_wrap = row_wrap;

endmodule

// File: tb/tb_loop_sequencer.sv
// Randomised scoreboard bench for loop_sequencer.
module tb_loop_sequencer;

   localparam int W = 4;

   typedef struct {
      bit is_done;
      int row;
      int col;
      bit last;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] rows_in = '0;
   logic [W-1:0] cols_in = '0;
   logic         ready = 1'b0;
   logic         busy, done, valid, last, cnt_en;
   logic [W-1:0] row, col;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   bit   rdy_pat[$];
   bit   rdy_rand = 1'b0;

   always #5 clk = ~clk;

   loop_sequencer #(
      .IDX_WIDTH(W)
   ) dut (
      .seq_clk     (clk),
      .seq_rst     (rst),
      .seq_start_i (start),
      .seq_rows_i  (rows_in),
      .seq_cols_i  (cols_in),
      .seq_busy_o  (busy),
      .seq_done_o  (done),
      .seq_valid_o (valid),
      .seq_ready_i (ready),
      .seq_row_o   (row),
      .seq_col_o   (col),
      .seq_last_o  (last),
      .seq_cnt_en_o(cnt_en)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_pat.size() > 0) ready = rdy_pat.pop_front();
      else if (rdy_rand) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
   end

   // Monitor: pops expectations on each handshake or done pulse.
   bit           prev_stall = 0, prev_done = 0, done_due = 0;
   logic [W-1:0] prev_row, prev_col;
   logic         prev_last;
   always @(negedge clk) begin
      exp_t e;
      bit   due_now;
      if (rst) begin
         prev_stall = 0;
         prev_done  = 0;
         done_due   = 0;
      end else begin
         due_now  = done_due;
         done_due = 0;
         check("cnt_en", int'(cnt_en), int'(valid & ready));
         if (due_now) check("done_latency", int'(done), 1);
         if (prev_done && done) check("done_width", 1, 0);
         if (!valid && last) check("last_when_idle", 1, 0);
         if (prev_stall) begin
            check("stall_valid", int'(valid), 1);
            check("stall_row", int'(row), int'(prev_row));
            check("stall_col", int'(col), int'(prev_col));
            check("stall_last", int'(last), int'(prev_last));
         end
         if (valid && ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               check("beat_kind", int'(e.is_done), 0);
               check("beat_row", int'(row), e.row);
               check("beat_col", int'(col), e.col);
               check("beat_last", int'(last), int'(e.last));
               done_due = e.last;
            end
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_kind", int'(e.is_done), 1);
            end
         end
         prev_stall = valid && !ready;
         prev_done  = done;
         prev_row   = row;
         prev_col   = col;
         prev_last  = last;
      end
   end

   task automatic drive_point();
      @(negedge clk);
      #1;
   endtask

   // Issues a start and pushes the reference beat list; returns at the N+1 drive point.
   task automatic launch(input int r, input int c);
      exp_t e;
      rows_in = W'(r);
      cols_in = W'(c);
      start   = 1'b1;
      for (int i = 0; i < r; i++) begin
         for (int j = 0; j < c; j++) begin
            e.is_done = 0;
            e.row     = i;
            e.col     = j;
            e.last    = (i == r - 1) && (j == c - 1);
            sb.push_back(e);
         end
      end
      e.is_done = 1;
      e.row = 0;
      e.col = 0;
      e.last = 0;
      sb.push_back(e);
      drive_point();
      start = 1'b0;
      if (r != 0 && c != 0) begin
         check("first_beat_valid", int'(valid), 1);
         check("first_beat_busy", int'(busy), 1);
      end else begin
         check("zero_done", int'(done), 1);
         check("zero_busy", int'(busy), 1);
         check("zero_valid", int'(valid), 0);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         drive_point();
         n++;
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_row"}, int'(row), 0);
      check({tag, "_col"}, int'(col), 0);
      check({tag, "_last"}, int'(last), 0);
      check({tag, "_cnt_en"}, int'(cnt_en), 0);
   endtask

   initial begin
      repeat (3) drive_point();
      check_quiet("reset");
      rst = 1'b0;
      drive_point();

      // 2x3 with ready held high
      rdy_rand = 0;
      launch(2, 3);
      wait_idle(100);

      // 1x4 with a fixed ready pattern
      rdy_pat = '{1, 0, 0, 1, 1, 0, 1};
      launch(1, 4);
      wait_idle(100);

      // zero bound
      launch(0, 5);
      drive_point();
      check("zero_busy_drop", int'(busy), 0);
      drive_point();

      // start during RUN is ignored
      launch(2, 2);
      rows_in = 7;
      cols_in = 7;
      start   = 1'b1;
      drive_point();
      start = 1'b0;
      wait_idle(100);
      rdy_rand = 1;
      launch(7, 7);
      wait_idle(1000);

      // reset after the third beat of a 3x3 run
      rdy_rand = 0;
      drive_point();
      launch(3, 3);
      drive_point();
      drive_point();
      rst = 1'b1;
      sb.delete();
      drive_point();
      check_quiet("abort");
      rst = 1'b0;
      drive_point();
      check_quiet("post_abort");
      launch(3, 3);
      wait_idle(100);

      // max bounds
      launch(15, 15);
      wait_idle(1000);

      // random runs
      for (int k = 0; k < 8; k++) begin
         rdy_rand = 1'($urandom_range(0, 1));
         launch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         wait_idle(2000);
      end

      repeat (3) drive_point();
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Two-level (row/column) index generator with a start/done handshake.
- Sits directly upstream of the counter stage. It emits one index beat per transfer on a valid/ready stream.
- It also produces a single-cycle enable per accepted beat, which drives the downstream counter's enable input.
- Loop bounds are captured at start, so the controller can reprogram them while the sequencer runs.

Parameters:
IDX_WIDTH, 4, width of row/column bounds and indices (max bound 2^IDX_WIDTH-1)

Ports:
seq_clk  input  1  clock; all logic on rising edge
seq_rst  input  1  synchronous, active-high reset
seq_start_i  input  1  start request; honoured only in IDLE
seq_rows_i  input  IDX_WIDTH  number of rows; sampled on accepted start
seq_cols_i  input  IDX_WIDTH  number of columns; sampled on accepted start
seq_busy_o  output  1  high whenever state != IDLE
seq_done_o  output  1  one-cycle pulse at end of a sequence
seq_valid_o  output  1  index beat valid
seq_ready_i  input  1  downstream accepts beat
seq_row_o  output  IDX_WIDTH  current row index
seq_col_o  output  IDX_WIDTH  current column index
seq_last_o  output  1  current beat is the final one (row=rows-1 and col=cols-1)
seq_cnt_en_o  output  1  equals seq_valid_o & seq_ready_i; drives the downstream counter enable

Behaviour:
- Clock and reset: one clock, seq_clk. Reset is synchronous and active-high on seq_rst.
- Reset values: state=IDLE; row=0, col=0; captured bounds=0; all outputs 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start with rows!=0 and cols!=0: capture both bounds, clear row/col, go to RUN.
  - start with rows==0 or cols==0: go to DONE; no beats are issued.
  - no start: stay in IDLE.
- RUN:
  - seq_valid_o=1 continuously.
  - Handshake fires when valid & ready.
  - On a non-last handshake: col+1. When col==cols-1, col wraps to 0 and row+1.
  - On the last handshake: go to DONE.
- DONE: seq_done_o=1 for exactly one cycle, then return to IDLE.
- Latency:
  - start accepted in cycle N gives the first beat (row=0, col=0) valid in N+1.
  - last handshake in cycle M gives done in M+1 and IDLE in M+2; a new start is accepted from M+2.
  - Zero-bound start in N gives done in N+1.
- Stability: while valid & !ready, row, col and last hold unchanged. Valid never drops in RUN without a handshake.
- Throughput: one beat per cycle when ready is held high. Total beats = rows*cols.
- Arithmetic and width rules:
  - Index compares use the captured bounds minus 1, at IDX_WIDTH width.
  - No overflow is possible because indices never exceed bound-1.
  - Max bounds (2^W-1 each) must work.
- Start outside IDLE (RUN/DONE): ignored; not queued; bounds are not re-sampled.
- Bound inputs changing during RUN: no effect.
- Reset mid-operation: abort immediately to reset values. No done pulse and no further cnt_en.
- seq_last_o: combinational from the registered indices and captured bounds; valid only while seq_valid_o=1, otherwise 0.

Decomposition:
- Shared package seq_pkg:
  - state enum typedef seq_state_e {IDLE, RUN, DONE}.
  - default IDX_WIDTH constant.
- Sub-module wrap_counter (IDX_WIDTH):
  - inputs: enable, terminal value, clear; outputs: index and a wrap flag.
  - instantiated twice: column, and row (row enabled by the column wrap).
- FSM and handshake logic stay in loop_sequencer.

Test Plan:
1. rows=2, cols=3, start, ready held 1 -> six beats (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on consecutive cycles starting N+1; last only on (1,2); done pulses 1 cycle after; six cnt_en pulses.
2. rows=1, cols=4, ready pattern 1,0,0,1,1,0,1 -> beats hold steady during ready=0; exactly 4 cnt_en pulses; indices 0..3 in order.
3. rows=0, cols=5 start -> no valid, no cnt_en; done=1 at N+1; busy high only for the N+1 cycle.
4. Start pulsed again mid-RUN with new bounds rows=7, cols=7 -> ignored; original 2x2 sequence completes with 4 beats; next start after IDLE uses the new values.
5. Reset asserted after beat 3 of a 3x3 run -> next cycle all outputs 0, state IDLE, no done; a fresh start then runs the full 9 beats.
6. rows=15, cols=15 (IDX_WIDTH=4), ready=1 -> 225 beats; final beat (14,14) with last=1; no index wrap past 14.
